// File: rtl/count_extend_readout.sv
// ---------------------------------------------------------------------------
// count_extend_readout
//
// Extends the toggling bit 0 of the upstream 1-bit counter cell into a
// WIDTH-bit count by counting its 1->0 transitions (carries out of bit 0),
// and offers a stable snapshot of that count through a valid/ack handshake
// so a test controller can read it without racing the live counter.
//
// Ports:
//   GCLK_Pad      in   clock, all state updates on the rising edge
//   rst_Pad       in   asynchronous active-low reset
//   count_Pad     in   bit 0 from the upstream counter cell
//   cnt_clr_Pad   in   synchronous clear mirroring the upstream reset
//   snap_req_Pad  in   capture request, only looked at while idle
//   ack_Pad       in   snapshot accepted, only looked at while holding
//   value_Pad     out  captured snapshot {upper, bit0}
//   valid_Pad     out  snapshot available
//   ovf_Pad       out  sticky overflow since the last accepted snapshot
// ---------------------------------------------------------------------------
module count_extend_readout #(
    parameter int WIDTH = 4
) (
    input  logic             GCLK_Pad,
    input  logic             rst_Pad,
    input  logic             count_Pad,
    input  logic             cnt_clr_Pad,
    input  logic             snap_req_Pad,
    input  logic             ack_Pad,
    output logic [WIDTH-1:0] value_Pad,
    output logic             valid_Pad,
    output logic             ovf_Pad
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [WIDTH-2:0] UPPER_ONE = 1;

    state_t           state_q, state_d;
    logic             prev_q,  prev_d;
    logic [WIDTH-2:0] upper_q, upper_d;
    logic [WIDTH-1:0] snap_q,  snap_d;
    logic             valid_q, valid_d;
    logic             ovf_q,   ovf_d;

    logic             carry;
    logic             wrap;
    logic             ack_accept;
    logic [WIDTH-1:0] live;

    // Carry is a falling edge of bit 0 as seen across one clock. A clear
    // masks it so the upstream reset's own 1->0 step is not counted.
    always_comb begin
        carry   = prev_q & ~count_Pad & ~cnt_clr_Pad;
        wrap    = carry & (&upper_q);
        live    = {upper_q, prev_q};

        prev_d  = cnt_clr_Pad ? 1'b0 : count_Pad;
        upper_d = upper_q;
        if (cnt_clr_Pad) begin
            upper_d = '0;
        end else if (carry) begin
            upper_d = upper_q + UPPER_ONE;
        end
    end

    // Handshake: capture the pre-update live value on a request in IDLE,
    // then hold it until acked. The counter keeps running either way.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        valid_d    = valid_q;
        ack_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req_Pad) begin
                    snap_d  = live;
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (ack_Pad) begin
                    state_d    = IDLE;
                    valid_d    = 1'b0;
                    ack_accept = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // A wrap on the same edge as an accepted ack must not be lost.
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (ack_accept) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge GCLK_Pad or negedge rst_Pad) begin
        if (!rst_Pad) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            upper_q <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            upper_q <= upper_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value_Pad = snap_q;
    assign valid_Pad = valid_q;
    assign ovf_Pad   = ovf_q;

endmodule

// File: tb/tb_count_extend_readout.sv
// ---------------------------------------------------------------------------
// tb_count_extend_readout
//
// Drives the extended counter with directed scenarios and random traffic.
// The reference keeps the upper count as a plain integer of carries modulo
// 2^(WIDTH-1), plus a holding flag, snapshot value and overflow flag.
// ---------------------------------------------------------------------------
module tb_count_extend_readout;

    localparam int WIDTH     = 4;
    localparam int UPPER_MOD = 1 << (WIDTH - 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             count = 1'b0;
    logic             clr   = 1'b0;
    logic             req   = 1'b0;
    logic             ack   = 1'b0;
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state
    int m_prev  = 0;
    int m_upper = 0;
    int m_snap  = 0;
    bit m_hold  = 1'b0;
    bit m_ovf   = 1'b0;

    always #5 clk = ~clk;

    count_extend_readout #(.WIDTH(WIDTH)) dut (
        .GCLK_Pad     (clk),
        .rst_Pad      (rst_n),
        .count_Pad    (count),
        .cnt_clr_Pad  (clr),
        .snap_req_Pad (req),
        .ack_Pad      (ack),
        .value_Pad    (value),
        .valid_Pad    (valid),
        .ovf_Pad      (ovf)
    );

    // Clear the reference to its post-reset state
    task automatic model_reset();
        m_prev  = 0;
        m_upper = 0;
        m_snap  = 0;
        m_hold  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the
    // reference at the rising edge, and return at the next falling edge.
    task automatic step(input logic c, input logic cl, input logic rq, input logic ak);
        bit carry;
        count = c;
        clr   = cl;
        req   = rq;
        ack   = ak;
        @(posedge clk);
        carry = (m_prev == 1) && !c && !cl;
        if (m_hold) begin
            if (ak) begin
                m_hold = 1'b0;
                m_ovf  = 1'b0;
            end
        end else if (rq) begin
            m_snap = m_upper * 2 + m_prev;
            m_hold = 1'b1;
        end
        if (cl) begin
            m_upper = 0;
            m_prev  = 0;
        end else begin
            if (carry) begin
                m_upper = (m_upper + 1) % UPPER_MOD;
                if (m_upper == 0) m_ovf = 1'b1;
            end
            m_prev = c ? 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        count = 1'b0;
        clr   = 1'b0;
        req   = 1'b0;
        ack   = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({value, valid, ovf} !== {WIDTH'(0), 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: value=%0h valid=%0b ovf=%0b, want 0/0/0", value, valid, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if ({value, valid, ovf} !== {WIDTH'(0), 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_idle: value=%0h valid=%0b ovf=%0b, want 0/0/0", value, valid, ovf);
        end
    endtask

    task automatic test_basic_count();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({value, valid, ovf} !== {4'b0100, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL basic_snapshot: value=%b valid=%0b ovf=%0b, want 0100/1/0", value, valid, ovf);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if ({value, valid} !== {4'b0100, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL basic_after_ack: value=%b valid=%0b, want 0100/0", value, valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 6 || i == 7) begin
                tests_run++;
                if (ovf !== (i == 7)) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_ovf_set carry=%0d: ovf=%0b, want %0b", i + 1, ovf, (i == 7));
                end
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({value, valid, ovf} !== {4'b0000, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL wrap_snapshot: value=%b valid=%0b ovf=%0b, want 0000/1/1", value, valid, ovf);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if ({valid, ovf} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL wrap_ack_clears: valid=%0b ovf=%0b, want 0/0", valid, ovf);
        end
        // Seven carries while holding, then the eighth lands on the ack edge
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if ({valid, ovf} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL wrap_pre_ack: valid=%0b ovf=%0b, want 1/0", valid, ovf);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if ({valid, ovf} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL wrap_on_ack_edge: valid=%0b ovf=%0b, want 0/1", valid, ovf);
        end
    endtask

    // Continues from test_wrap so ovf is already set when the clear arrives
    task automatic test_clear();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({value, valid, ovf} !== {4'b0000, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL clear_snapshot: value=%b valid=%0b ovf=%0b, want 0000/1/1", value, valid, ovf);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_carry_capture();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({value, valid} !== {4'b0101, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL carry_capture_pre: value=%b valid=%0b, want 0101/1", value, valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({value, valid} !== {4'b0110, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL carry_capture_post: value=%b valid=%0b, want 0110/1", value, valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_hold_ignore();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step((i % 2) == 0, 1'b0, (i % 2) == 1, 1'b0);
            tests_run++;
            if ({value, valid} !== {4'b0001, 1'b1}) begin
                tests_failed++;
                $display("[TB] FAIL hold_stable cyc=%0d: value=%b valid=%0b, want 0001/1", i, value, valid);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if ({value, valid, ovf} !== {4'b0001, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL idle_ack_ignored: value=%b valid=%0b ovf=%0b, want 0001/0/0", value, valid, ovf);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({value, valid, ovf} !== {4'b0100, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL mid_hold_setup: value=%b valid=%0b ovf=%0b, want 0100/1/1", value, valid, ovf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({value, valid, ovf} !== {4'b0000, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL mid_hold_async_reset: value=%b valid=%0b ovf=%0b, want 0000/0/0", value, valid, ovf);
        end
        count = 1'b0;
        req   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({value, valid, ovf} !== {4'b0010, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_snapshot: value=%b valid=%0b ovf=%0b, want 0010/1/0", value, valid, ovf);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] exp_value;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
            exp_value = m_snap[WIDTH-1:0];
            tests_run++;
            if ({value, valid, ovf} !== {exp_value, m_hold, m_ovf}) begin
                tests_failed++;
                $display("[TB] FAIL random cyc=%0d: value=%b valid=%0b ovf=%0b, want %b/%0b/%0b",
                         i, value, valid, ovf, exp_value, m_hold, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_wrap();
        test_clear();
        test_carry_capture();
        test_hold_ignore();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/count_extend_readout.md
Name: count_extend_readout

Overview:
- Downstream stage of the 1-bit enable/reset counter cell. It consumes that cell's toggling output bit (count_Pad) and extends it to a WIDTH-bit count by detecting 1->0 transitions, which are carries out of bit 0.
- Provides a snapshot readout with a valid/ack handshake and a sticky overflow flag, so the on-chip test controller can read the extended count without racing the live counter.

Parameters:
- WIDTH, 4, total count width including bit 0 from the upstream cell; legal range 2..16.

Ports:
- GCLK_Pad  in  1  clock; all state updates on rising edge.
- rst_Pad  in  1  asynchronous, active-low reset.
- count_Pad  in  1  bit 0 from the upstream 1-bit counter; toggles once per enabled cycle.
- cnt_clr_Pad  in  1  synchronous, active-high mirror of the upstream counter's reset; clears the upper count and suppresses carry detection.
- snap_req_Pad  in  1  request to capture the current count; sampled only in IDLE.
- ack_Pad  in  1  consumer accepts the snapshot; sampled only in HOLD.
- value_Pad  out  WIDTH  captured snapshot {upper, bit0}; stable while valid_Pad=1.
- valid_Pad  out  1  snapshot available.
- ovf_Pad  out  1  sticky overflow: upper count wrapped since the last accepted snapshot.

Behaviour:
- Reset (rst_Pad=0, asynchronous):
  - prev_q=0, upper_q=0, snapshot=0, state=IDLE.
  - Outputs: value_Pad=0, valid_Pad=0, ovf_Pad=0.
  - Release is synchronous to the next rising edge.
- Live count is registered: live = {upper_q[WIDTH-2:0], prev_q}. It lags count_Pad by exactly one cycle.
- Every rising edge: prev_q <= count_Pad.
- Carry = prev_q & ~count_Pad & ~cnt_clr_Pad.
  - On carry: upper_q <= upper_q + 1, modulo 2^(WIDTH-1).
  - On carry with upper_q all-ones: upper_q wraps to 0 and ovf is set.
- cnt_clr_Pad=1:
  - upper_q <= 0 and prev_q <= 0, regardless of count_Pad.
  - No carry is counted, so the upstream reset's 1->0 transition is not a false carry.
  - ovf is not cleared.
- Handshake FSM, two states:
  - IDLE: valid_Pad=0. If snap_req_Pad=1 at the edge, snapshot <= live (pre-update value of that same edge) and go to HOLD. Otherwise stay in IDLE.
  - HOLD: valid_Pad=1 and value_Pad=snapshot, held constant. snap_req_Pad is ignored. If ack_Pad=1 at the edge, go to IDLE; valid_Pad falls the following cycle.
- Request-to-valid latency is 1 cycle. Minimum request-to-request spacing is 2 cycles (req, ack).
- ack_Pad in IDLE is ignored.
- Overflow:
  - ovf_Pad is set on a wrap.
  - Cleared on the edge where an ack is accepted in HOLD.
  - Wrap and accepted ack on the same edge: set wins, ovf_Pad stays 1.
- value_Pad holds the last snapshot after returning to IDLE. It changes only at a capture.
- Counting continues uninterrupted during HOLD. Snapshots never stall the counter.
- Simultaneous carry and capture: the snapshot holds the pre-increment value.
- Reset mid-HOLD: valid_Pad drops immediately (asynchronous); snapshot and ovf are cleared.

Test Plan:
1. Reset, then drive count_Pad 0,1,0,1,0 on successive cycles, then request a snapshot -> snapshot 4'b0100, valid_Pad=1 one cycle after the request, ovf_Pad=0.
2. Toggle count_Pad for 16 carries with WIDTH=4 -> upper_q wraps 7->0 on the 8th carry and ovf_Pad=1. A snapshot after 16 carries reads 4'b0000. ovf_Pad clears on the cycle after ack, unless a wrap occurs on the ack edge, in which case it stays 1.
3. Hold prev_q=1 (live=4'b0011) and drive cnt_clr_Pad=1 with count_Pad=0 -> no increment; live becomes 0. A following snapshot reads 4'b0000 and ovf_Pad is unchanged.
4. Carry and snap_req_Pad on the same edge with live=4'b0101 -> snapshot 4'b0101; live becomes 4'b0110 one cycle later.
5. In HOLD, pulse snap_req_Pad while counting continues -> value_Pad stays fixed and valid_Pad stays 1 until ack; ack_Pad=1 in IDLE causes no change.
6. Assert rst_Pad=0 mid-HOLD between clock edges -> valid_Pad, value_Pad and ovf_Pad go to 0 immediately. The first post-release snapshot reflects only carries after release.
